rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_queue_pkg.sv | 27 ++
 rtl/rob_queue.sv | 181 ++++++++++++++++++
 tb/tb_rob_queue.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_queue_pkg.sv
// Shared CPU definitions: reorder-buffer entry types, default ROB index width
// and the per-entry allocation payload used by dispatcher, ROB and register file.
package rob_queue_pkg;

  localparam int unsigned ROB_WIDTH_DEFAULT = 3;
  localparam int unsigned XLEN              = 32;
  localparam int unsigned REG_W             = 5;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2
  } rob_type_e;

  // Static part of an entry, captured at allocation time
  typedef struct packed {
    rob_type_e         kind;
    logic [REG_W-1:0]  rd;
    logic              pred_taken;
    logic [XLEN-1:0]   alt_pc;
  } rob_entry_t;

  function automatic logic is_mispredict(input rob_entry_t e, input logic taken);
    return (e.kind == TYPE_BRANCH) && (taken != e.pred_taken);
  endfunction

endpackage

// File: rtl/rob_queue.sv
// Reorder buffer: circular queue with in-order commit, CDB writeback and branch flush.
// Optional operand query enabled by defining ROB_QUERY_EN.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [REG_W-1:0]     alloc_rd,
  input  logic                 alloc_pred_taken,
  input  logic [XLEN-1:0]      alloc_alt_pc,
  output logic [ROB_WIDTH-1:0] alloc_index,
  output logic                 full,
  input  logic                 cdb_en,
  input  logic [ROB_WIDTH-1:0] cdb_index,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic                 cdb_taken,
  input  logic [ROB_WIDTH-1:0] q1_index,
  input  logic [ROB_WIDTH-1:0] q2_index,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [XLEN-1:0]      q1_data,
  output logic [XLEN-1:0]      q2_data,
  output logic                 commit_en,
  output logic [REG_W-1:0]     commit_rd,
  output logic [ROB_WIDTH-1:0] commit_index,
  output logic [XLEN-1:0]      commit_data,
  output logic                 store_commit,
  output logic [ROB_WIDTH-1:0] store_index,
  output logic                 flush,
  output logic [XLEN-1:0]      flush_pc
);

  localparam int unsigned ROB_SIZE = 2 ** ROB_WIDTH;
  localparam int unsigned CNT_W    = ROB_WIDTH + 1;

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [CNT_W-1:0]     count;
  logic [ROB_SIZE-1:0]  valid;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_SIZE-1:0]  taken;
  rob_entry_t           entry [ROB_SIZE];
  logic [XLEN-1:0]      data  [ROB_SIZE];

  rob_entry_t head_entry;
  logic       do_commit;
  logic       mispredict;
  logic       blocked;
  logic       do_alloc;
  logic       do_cdb;

  assign full        = (count == CNT_W'(ROB_SIZE));
  assign alloc_index = tail;

  // Per-edge decisions; a flushing edge and the flush cycle swallow alloc/CDB
  always_comb begin
    head_entry = entry[head];
    do_commit  = 1'b0;
    mispredict = 1'b0;
    blocked    = 1'b0;
    do_alloc   = 1'b0;
    do_cdb     = 1'b0;
    do_commit  = rdy_in && (count != '0) && valid[head] && ready[head];
    mispredict = do_commit && is_mispredict(head_entry, taken[head]);
    blocked    = flush || mispredict;
    do_alloc   = rdy_in && alloc_en && !full && !blocked;
    do_cdb     = rdy_in && cdb_en && valid[cdb_index] && !blocked;
  end

  // Queue control, status bits and registered commit/flush outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      ready        <= '0;
      taken        <= '0;
      commit_en    <= 1'b0;
      commit_rd    <= '0;
      commit_index <= '0;
      commit_data  <= '0;
      store_commit <= 1'b0;
      store_index  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_en    <= 1'b0;
      store_commit <= 1'b0;
      flush        <= 1'b0;
      if (do_cdb) begin
        taken[cdb_index] <= cdb_taken;
        ready[cdb_index] <= 1'b1;
      end
      if (do_commit) begin
        valid[head]  <= 1'b0;
        ready[head]  <= 1'b0;
        head         <= head + ROB_WIDTH'(1);
        commit_rd    <= head_entry.rd;
        commit_index <= head;
        commit_data  <= data[head];
        if (head_entry.kind == TYPE_REG && head_entry.rd != '0) begin
          commit_en <= 1'b1;
        end
        if (head_entry.kind == TYPE_STORE) begin
          store_commit <= 1'b1;
          store_index  <= head;
        end
      end
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + ROB_WIDTH'(1);
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mispredict) begin
        valid    <= '0;
        ready    <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        flush    <= 1'b1;
        flush_pc <= head_entry.alt_pc;
      end
    end
  end

  // Entry payload storage; contents are only meaningful while valid/ready say so
  always_ff @(posedge clk_in) begin
    if (do_cdb) begin
      data[cdb_index] <= cdb_data;
    end
    if (do_alloc) begin
      entry[tail] <= '{kind:       rob_type_e'(alloc_type),
                       rd:         alloc_rd,
                       pred_taken: alloc_pred_taken,
                       alt_pc:     alloc_alt_pc};
    end
  end

`ifdef ROB_QUERY_EN
  // Operand lookup with same-cycle CDB bypass
  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    q2_ready = 1'b0;
    q2_data  = '0;
    if (cdb_en && cdb_index == q1_index) begin
      q1_ready = 1'b1;
      q1_data  = cdb_data;
    end else if (valid[q1_index] && ready[q1_index]) begin
      q1_ready = 1'b1;
      q1_data  = data[q1_index];
    end
    if (cdb_en && cdb_index == q2_index) begin
      q2_ready = 1'b1;
      q2_data  = cdb_data;
    end else if (valid[q2_index] && ready[q2_index]) begin
      q2_ready = 1'b1;
      q2_data  = data[q2_index];
    end
  end
`else
  logic unused_query;
  assign unused_query = ^{q1_index, q2_index};
  assign q1_ready     = 1'b0;
  assign q2_ready     = 1'b0;
  assign q1_data      = '0;
  assign q2_data      = '0;
`endif

endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue: scoreboard of expected commit/store/flush
// events compared against events observed on the DUT outputs.
module tb_rob_queue;

`ifdef ROB_QUERY_EN
  localparam bit QE = 1'b1;
`else
  localparam bit QE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in, alloc_en, alloc_pred_taken, cdb_en, cdb_taken;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_alt_pc, cdb_data;
  logic [2:0]  alloc_index, cdb_index, q1_index, q2_index;
  logic        full, q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_en, store_commit, flush;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_index, store_index;
  logic [31:0] commit_data, flush_pc;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [2:0]  idx;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  rob_queue #(.ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
    .alloc_index(alloc_index), .full(full),
    .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
    .q1_index(q1_index), .q2_index(q2_index), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_index(commit_index),
    .commit_data(commit_data), .store_commit(store_commit), .store_index(store_index),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  function automatic ev_t mk(input logic [1:0] k, input logic [4:0] r,
                             input logic [2:0] i, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.rd = r; e.idx = i; e.data = d;
    return e;
  endfunction

  // Event monitor: one entry per output pulse, sampled mid-cycle
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (commit_en)    obs_q.push_back(mk(2'd0, commit_rd, commit_index, commit_data));
      if (store_commit) obs_q.push_back(mk(2'd1, 5'd0, store_index, 32'd0));
      if (flush)        obs_q.push_back(mk(2'd2, 5'd0, 3'd0, flush_pc));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] r,
                       input logic p, input logic [31:0] a);
    alloc_en = 1'b1; alloc_type = t; alloc_rd = r; alloc_pred_taken = p; alloc_alt_pc = a;
    tick();
    alloc_en = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] i, input logic [31:0] d, input logic tk);
    cdb_en = 1'b1; cdb_index = i; cdb_data = d; cdb_taken = tk;
    tick();
    cdb_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
    tick();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    ev_t e, o;
    rdy_in = 1'b1; alloc_en = 1'b0; alloc_type = 2'd0; alloc_rd = 5'd0;
    alloc_pred_taken = 1'b0; alloc_alt_pc = 32'd0; cdb_en = 1'b0; cdb_index = 3'd0;
    cdb_data = 32'd0; cdb_taken = 1'b0; q1_index = 3'd0; q2_index = 3'd0;
    #1 rst_in = 1'b1;
    #1;
    checks++;
    if ({full, commit_en, store_commit, flush} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {full, commit_en, store_commit, flush});
    end
    checks++;
    if ({alloc_index, commit_rd, commit_index, commit_data, store_index, flush_pc} !== '0) begin
      errors++; $display("FAIL reset_values got idx=%0d rd=%0d data=%h pc=%h expected all 0",
                         alloc_index, commit_rd, commit_data, flush_pc);
    end
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  // Fill to full, commit out of CDB order, then reset with a commit pending
  task automatic test_fill_and_order();
    ev_t e, o;
    for (int i = 1; i <= 8; i++) begin
      alloc(2'd0, 5'(i), 1'b0, 32'd0);
      if (i == 7) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL fill_not_full got %b expected 0", full); end
      end
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b expected 1", full); end
    alloc(2'd0, 5'd9, 1'b0, 32'd0);
    checks++;
    if (alloc_index !== 3'd0 || full !== 1'b1) begin
      errors++; $display("FAIL fill_ignore got idx=%0d full=%b expected idx=0 full=1", alloc_index, full);
    end
    cdb(3'd2, 32'hA2, 1'b0);
    cdb(3'd0, 32'hA0, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd1, 3'd0, 32'hA0));
    cdb(3'd1, 32'hA1, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd2, 3'd1, 32'hA1));
    exp_q.push_back(mk(2'd0, 5'd3, 3'd2, 32'hA2));
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL order_commit got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL order_commit got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL order_extra got %0d events expected 0", obs_q.size()); end
    obs_q.delete();
    // five entries live, entry 3 ready to commit at the next edge
    cdb(3'd3, 32'hA3, 1'b0);
    rst_in = 1'b1;
    #1;
    checks++;
    if ({full, commit_en, store_commit, flush, alloc_index} !== 7'b0) begin
      errors++; $display("FAIL reset_live got full=%b ce=%b sc=%b fl=%b idx=%0d expected all 0",
                         full, commit_en, store_commit, flush, alloc_index);
    end
    #1 rst_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 0 || alloc_index !== 3'd0) begin
      errors++; $display("FAIL reset_after got events=%0d idx=%0d expected 0 0", obs_q.size(), alloc_index);
    end
    obs_q.delete();
  endtask

  task automatic test_flush();
    ev_t e, o;
    do_reset();
    alloc(2'd2, 5'd0, 1'b0, 32'h1000);
    alloc(2'd0, 5'd5, 1'b0, 32'd0);
    alloc(2'd0, 5'd6, 1'b0, 32'd0);
    alloc(2'd0, 5'd7, 1'b0, 32'd0);
    cdb(3'd1, 32'h51, 1'b0);
    cdb(3'd2, 32'h52, 1'b0);
    cdb(3'd3, 32'h53, 1'b0);
    cdb(3'd0, 32'h0, 1'b1);
    exp_q.push_back(mk(2'd2, 5'd0, 3'd0, 32'h1000));
    alloc_en = 1'b1; alloc_type = 2'd0; alloc_rd = 5'd9;
    tick();
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h1000) begin
      errors++; $display("FAIL flush_pulse got flush=%b pc=%h expected 1 00001000", flush, flush_pc);
    end
    tick();
    alloc_en = 1'b0;
    checks++;
    if (flush !== 1'b0 || alloc_index !== 3'd0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_after got flush=%b idx=%0d full=%b expected 0 0 0", flush, alloc_index, full);
    end
    alloc(2'd0, 5'd9, 1'b0, 32'd0);
    checks++;
    if (alloc_index !== 3'd1) begin errors++; $display("FAIL flush_realloc got %0d expected 1", alloc_index); end
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL flush_event got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL flush_event got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL flush_extra got %0d events expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_store();
    ev_t e, o;
    do_reset();
    alloc(2'd0, 5'd0, 1'b0, 32'd0);
    alloc(2'd1, 5'd4, 1'b0, 32'd0);
    alloc(2'd2, 5'd0, 1'b1, 32'h2000);
    cdb(3'd0, 32'h11, 1'b0);
    cdb(3'd1, 32'h22, 1'b0);
    exp_q.push_back(mk(2'd1, 5'd0, 3'd1, 32'd0));
    cdb(3'd2, 32'h33, 1'b1);
    repeat (4) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL store_event got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL store_event got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL store_extra got %0d events expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  // Simultaneous alloc+commit, pause via rdy_in, then refill to full
  task automatic test_back_to_back();
    ev_t e, o;
    do_reset();
    alloc(2'd0, 5'd10, 1'b0, 32'd0);
    alloc(2'd0, 5'd11, 1'b0, 32'd0);
    cdb(3'd0, 32'h55, 1'b0);
    exp_q.push_back(mk(2'd0, 5'd10, 3'd0, 32'h55));
    alloc(2'd0, 5'd12, 1'b0, 32'd0);
    checks++;
    if (alloc_index !== 3'd3) begin errors++; $display("FAIL b2b_index got %0d expected 3", alloc_index); end
    cdb(3'd1, 32'h66, 1'b0);
    rdy_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 1 || commit_en !== 1'b0) begin
      errors++; $display("FAIL pause_hold got events=%0d ce=%b expected 1 0", obs_q.size(), commit_en);
    end
    rdy_in = 1'b1;
    exp_q.push_back(mk(2'd0, 5'd11, 3'd1, 32'h66));
    for (int i = 1; i <= 7; i++) begin
      alloc(2'd0, 5'(12 + i), 1'b0, 32'd0);
      if (i == 6) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL b2b_not_full got %b expected 0", full); end
      end
    end
    checks++;
    if (full !== 1'b1 || alloc_index !== 3'd2) begin
      errors++; $display("FAIL b2b_full got full=%b idx=%0d expected 1 2", full, alloc_index);
    end
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_event got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_event got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d events expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_query();
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) alloc(2'd0, 5'(20 + i), 1'b0, 32'd0);
    exp_d = QE ? 32'hDEADBEEF : 32'd0;
    q1_index = 3'd3; q2_index = 3'd1;
    cdb_en = 1'b1; cdb_index = 3'd3; cdb_data = 32'hDEADBEEF; cdb_taken = 1'b0;
    #1;
    checks++;
    if (q1_ready !== QE || q1_data !== exp_d) begin
      errors++; $display("FAIL query_bypass got rdy=%b data=%h expected %b %h", q1_ready, q1_data, QE, exp_d);
    end
    checks++;
    if (q2_ready !== 1'b0 || q2_data !== 32'd0) begin
      errors++; $display("FAIL query_notready got rdy=%b data=%h expected 0 0", q2_ready, q2_data);
    end
    tick();
    cdb_en = 1'b0;
    #1;
    checks++;
    if (q1_ready !== QE || q1_data !== exp_d) begin
      errors++; $display("FAIL query_stored got rdy=%b data=%h expected %b %h", q1_ready, q1_data, QE, exp_d);
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL query_extra got %0d events expected 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill_and_order();
    test_flush();
    test_store();
    test_back_to_back();
    test_query();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
